// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol/disparity widths and the four control tokens
// that both the encoder and the receive-side token detector rely on.
package tmds_pkg;

  localparam int SYM_W  = 10;
  localparam int DISP_W = 5;

  localparam logic [SYM_W-1:0] CT0 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CT1 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CT2 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CT3 = 10'b1010101011;

  function automatic logic [SYM_W-1:0] ctrl_token(input logic [1:0] c);
    logic [SYM_W-1:0] tok;
    case (c)
      2'b00:   tok = CT0;
      2'b01:   tok = CT1;
      2'b10:   tok = CT2;
      2'b11:   tok = CT3;
      default: tok = CT0;
    endcase
    return tok;
  endfunction

endpackage

// File: rtl/tmds_popcount8.sv
// Combinational ones-count of an 8-bit vector.
module tmds_popcount8 (
  input  logic [7:0] data_i,
  output logic [3:0] count_o
);

  always_comb begin
    count_o = 4'd0;
    for (int i = 0; i < 8; i++) begin
      count_o = count_o + {3'b000, data_i[i]};
    end
  end

endmodule

// File: rtl/tmds_channel_encoder.sv
// Single-channel TMDS encoder: transition-minimising stage 1, DC-balancing stage 2
// with a running disparity counter; control tokens during blanking.
module tmds_channel_encoder
  import tmds_pkg::*;
#(
  parameter int PIPE_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             de,
  input  logic [7:0]       d,
  input  logic [1:0]       c,
  output logic [SYM_W-1:0] q_out,
  output logic             q_valid
);

  if (PIPE_STAGES != 2) begin : g_bad_pipe_stages
    $error("tmds_channel_encoder: PIPE_STAGES must be 2");
  end

  logic [3:0]              d_ones;
  logic [3:0]              qm_ones;
  logic                    use_xnor;
  logic [8:0]              q_m_d, q_m_q;
  logic                    de_q;
  logic [1:0]              c_q;
  logic signed [DISP_W-1:0] cnt_d, cnt_q;
  logic [SYM_W-1:0]        q_out_d, q_out_q;
  logic                    valid1_q, q_valid_q;

  logic                    q8;
  logic signed [5:0]       diff;
  logic signed [5:0]       cnt6;
  logic signed [5:0]       two_q8;
  logic signed [5:0]       nxt6;

  tmds_popcount8 u_pop_d  (.data_i(d),            .count_o(d_ones));
  tmds_popcount8 u_pop_qm (.data_i(q_m_q[7:0]),   .count_o(qm_ones));

  always_comb begin
    logic prev;
    use_xnor = (d_ones > 4'd4) || ((d_ones == 4'd4) && !d[0]);
    prev     = d[0];
    q_m_d    = 9'd0;
    q_m_d[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      prev     = use_xnor ? ~(prev ^ d[i]) : (prev ^ d[i]);
      q_m_d[i] = prev;
    end
    q_m_d[8] = ~use_xnor;
  end

  // diff is n1-n0 of q_m[7:0]; all disparity math is 6-bit signed, truncated to 5.
  always_comb begin
    q8      = q_m_q[8];
    diff    = $signed({1'b0, qm_ones, 1'b0}) - 6'sd8;
    cnt6    = {cnt_q[DISP_W-1], cnt_q};
    two_q8  = {4'b0000, q8, 1'b0};
    nxt6    = 6'sd0;
    q_out_d = ctrl_token(c_q);
    cnt_d   = 5'sd0;
    if (de_q) begin
      if ((cnt_q == 5'sd0) || (diff == 6'sd0)) begin
        q_out_d = {~q8, q8, q8 ? q_m_q[7:0] : ~q_m_q[7:0]};
        nxt6    = q8 ? (cnt6 + diff) : (cnt6 - diff);
      end else if (((cnt_q > 5'sd0) && (diff > 6'sd0)) ||
                   ((cnt_q < 5'sd0) && (diff < 6'sd0))) begin
        q_out_d = {1'b1, q8, ~q_m_q[7:0]};
        nxt6    = cnt6 + two_q8 - diff;
      end else begin
        q_out_d = {1'b0, q8, q_m_q[7:0]};
        nxt6    = cnt6 - (q8 ? 6'sd0 : 6'sd2) + diff;
      end
      cnt_d = nxt6[DISP_W-1:0];
    end else begin
      q_out_d = ctrl_token(c_q);
      cnt_d   = 5'sd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_m_q     <= 9'd0;
      de_q      <= 1'b0;
      c_q       <= 2'b00;
      q_out_q   <= CT0;
      cnt_q     <= 5'sd0;
      valid1_q  <= 1'b0;
      q_valid_q <= 1'b0;
    end else if (ce) begin
      if (de) begin
        q_m_q <= q_m_d;
      end else begin
        c_q <= c;
      end
      de_q      <= de;
      q_out_q   <= q_out_d;
      cnt_q     <= cnt_d;
      valid1_q  <= 1'b1;
      q_valid_q <= valid1_q;
    end
  end

  assign q_out   = q_out_q;
  assign q_valid = q_valid_q;

endmodule
